hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational decode hazard check.
- Tracks in-flight register writes in a per-register scoreboard, so RAW/WAW checks no longer compare against fixed E/M/W destination ports.
- Supports multi-cycle execute ops (mul/div) and produces bypass selects.
- Sits beside decode and drives IF/ID stall, ID/EX bubble and redirect flush controls.

Parameters:
- NREG, 32: architectural registers; index width RW = $clog2(NREG).
- NSTAGE, 3: stages from EX output to writeback (E, M, W); bypass sources tracked.
- LAT_W, 4: width of per-entry result countdown; fixed latency max 2**LAT_W-1.
- LOAD_LAT, 2: issue-to-result cycles for loads; ALU latency is fixed at 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  valid instruction in decode
- id_ra1, id_ra2  in  RW  source register indices
- id_use1, id_use2  in  1  source actually read
- id_rd  in  RW  destination index
- id_wen  in  1  instruction writes id_rd
- id_cls  in  2  latency class: 0 ALU, 1 LOAD, 2 LONG (mul/div), 3 none
- long_done  in  1  long unit result valid this cycle
- long_rd  in  RW  destination of completing long op
- wb_valid  in  1  writeback commits this cycle
- wb_rd  in  RW  writeback destination
- ex_redirect  in  1  branch/jalr resolved taken in EX
- stall_if  out  1  hold PC and IF/ID register
- bubble_ex  out  1  insert NOP into ID/EX
- flush_if_id  out  1  clear IF/ID
- issue  out  1  decode instruction advances this cycle
- fwd_sel1, fwd_sel2  out  2  0 regfile, 1 EX, 2 MEM, 3 WB bypass
- long_busy  out  1  long unit occupied

Behaviour:
- Entry per register r≠0: pend, rdy, cnt[LAT_W], age[2]. x0 is never pending. All entries are cleared on reset.
- Reset: all outputs 0, except fwd_selN=0 and long_busy=0.
- Source hazard, per source: used and ra≠0 and pend[ra] and not (wb_valid and wb_rd==ra).
  - Writeback in the same cycle counts as not pending, because the regfile is write-first.
  - The source stalls if the entry is not yet readable (see Optional Feature).
- WAW: id_wen and id_rd≠0 and pend[id_rd] not cleared this cycle -> stall.
- Structural: id_cls==LONG and long_busy and not long_done -> stall.
- stall = id_valid & (any hazard) & ~ex_redirect.
  - stall_if = stall; bubble_ex = stall | ex_redirect.
  - issue = id_valid & ~stall & ~ex_redirect.
- ex_redirect: flush_if_id = 1 and bubble_ex = 1 in the same cycle. The instruction in ID is not issued and not recorded. Existing entries are kept, since they are older and valid.
- On issue with id_wen and id_rd≠0, the entry loads next edge:
  - pend=1, age=0.
  - ALU: cnt=1. LOAD: cnt=LOAD_LAT. LONG: rdy=0, cnt ignored, long_busy=1.
  - cls 3: no write recorded.
- Each cycle, for pending non-LONG entries with cnt>0: cnt-=1. At the transition to cnt==0, rdy=1.
- While rdy and age<NSTAGE-1: age+=1. fwd source = age+1 (EX, MEM, WB).
- long_done: rdy[long_rd]=1, age=0, long_busy=0 next edge.
- wb_valid: pend[wb_rd]=0 next edge. If issue targets the same rd in the same cycle, issue wins (new entry).
- fwd_selN is combinational. It is 0 when the source is not used, is x0, is not pending, or is being written back this cycle. Otherwise it is age+1 of the entry.
- Outputs are valid only when id_valid; otherwise stall=0 and fwd_sel=0.
- Reset mid-operation clears all entries and long_busy immediately. No pending state survives.

Optional Feature:
- Macro HAZARD_FORWARD_EN.
- Defined: a source is readable when rdy=1, so a pending register is bypassed via fwd_selN. Load-use costs exactly LOAD_LAT-1 stall cycles; ALU back-to-back costs 0.
- Undefined: a source is readable only when not pending (writeback this cycle counts as not pending). fwd_selN is tied to 0 and rdy/age logic is removed. This gives a full-stall design equivalent in policy to the current pipeline.

Decomposition:
- Package pipes gets lat_cls_t enum (CLS_ALU, CLS_LOAD, CLS_LONG, CLS_NONE), fwd_sel_t enum (FWD_RF, FWD_EX, FWD_MEM, FWD_WB), and sb_entry_t struct {pend, rdy, cnt, age}.
- A sub-module hazard_sb_entry holds one entry's update logic and is instantiated NREG-1 times. The top level keeps the source-check, stall and flush combinational logic.

Test Plan:
- Back-to-back: ADDI x5 then ADD x6,x5,x5 -> with FORWARD_EN: no stall, fwd_sel1=fwd_sel2=1. Without: stall_if=1 for 3 cycles until wb_rd=5.
- Load-use: LD x7 then ADDI x8,x7 -> with FORWARD_EN: exactly 1 stall cycle, then fwd_sel1=1.
- Long op: MUL x9 issue, long_done after 10 cycles; a dependent use of x9 stalls 10 cycles. A second MUL while busy stalls until long_done, and long_busy drops 1 cycle after.
- WAW and same-cycle clear: x10 pending, issue writing x10 -> stall. With wb_valid and wb_rd=10 in that cycle -> issue=1 and pend[10] stays 1.
- Redirect: ex_redirect=1 while ID holds a hazarded instruction -> flush_if_id=1, bubble_ex=1, stall_if=0, no entry created. Uses of x0 never stall.
- Async reset asserted mid-LONG -> long_busy=0 and all pend=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/pipes.sv
// Shared types for the decode hazard scoreboard: latency classes, bypass selects and the per-register entry.
// Forwarding support is selected in the RTL by HAZARD_FORWARD_EN.
package pipes;

  localparam int unsigned SB_LAT_W = 4;
  localparam int unsigned AGE_W    = 2;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_LONG = 2'd2,
    CLS_NONE = 2'd3
  } lat_cls_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic                pend;
    logic                rdy;
    logic [SB_LAT_W-1:0] cnt;
    logic [AGE_W-1:0]    age;
  } sb_entry_t;

  // Bypass source for a result that has been readable for 'age' cycles.
  function automatic fwd_sel_t age_to_fwd(input logic [AGE_W-1:0] age);
    return fwd_sel_t'(age + 2'd1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: pending flag, result countdown and bypass age of a single register.
// rdy/cnt/age tracking exists only when HAZARD_FORWARD_EN is defined.
module hazard_sb_entry
  import pipes::*;
#(
  parameter int unsigned NSTAGE = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc,
  input  logic [SB_LAT_W-1:0] alloc_cnt,
  input  logic                alloc_rdy,
  input  logic                wb_clr,
  input  logic                long_hit,
  output sb_entry_t           entry
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NSTAGE - 1);

  sb_entry_t q, d;

  // Allocation beats a same-cycle writeback clear: the new producer is younger.
  always_comb begin
    d = q;
    if (alloc) begin
      d.pend = 1'b1;
      d.age  = '0;
`ifdef HAZARD_FORWARD_EN
      d.rdy  = alloc_rdy;
      d.cnt  = alloc_cnt;
`else
      d.rdy  = 1'b0;
      d.cnt  = '0;
`endif
    end else if (wb_clr) begin
      d = '0;
    end
`ifdef HAZARD_FORWARD_EN
    else if (q.pend) begin
      if (long_hit) begin
        d.rdy = 1'b1;
        d.age = '0;
      end else if (q.cnt != '0) begin
        d.cnt = q.cnt - SB_LAT_W'(1);
        if (q.cnt == SB_LAT_W'(1)) d.rdy = 1'b1;
      end else if (q.rdy && (q.age < AGE_MAX)) begin
        d.age = q.age + AGE_W'(1);
      end
    end
`endif
  end

`ifndef HAZARD_FORWARD_EN
  logic unused_in;
  assign unused_in = ^{alloc_cnt, alloc_rdy, long_hit, AGE_MAX};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end

  assign entry = q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side RAW/WAW/structural hazard scoreboard driving IF/ID stall, ID/EX bubble, flush and bypass selects.
// Define HAZARD_FORWARD_EN to bypass ready results; otherwise pending sources stall until writeback.
module hazard_scoreboard
  import pipes::*;
#(
  parameter  int unsigned NREG     = 32,
  parameter  int unsigned NSTAGE   = 3,
  parameter  int unsigned LAT_W    = SB_LAT_W,
  parameter  int unsigned LOAD_LAT = 2,
  localparam int unsigned RW       = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RW-1:0] id_ra1,
  input  logic [RW-1:0] id_ra2,
  input  logic          id_use1,
  input  logic          id_use2,
  input  logic [RW-1:0] id_rd,
  input  logic          id_wen,
  input  logic [1:0]    id_cls,
  input  logic          long_done,
  input  logic [RW-1:0] long_rd,
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_rd,
  input  logic          ex_redirect,
  output logic          stall_if,
  output logic          bubble_ex,
  output logic          flush_if_id,
  output logic          issue,
  output logic [1:0]    fwd_sel1,
  output logic [1:0]    fwd_sel2,
  output logic          long_busy
);

  // Entry is loaded with the issue cycle's countdown step already applied.
  localparam logic [LAT_W-1:0] LOAD_CNT = LAT_W'(LOAD_LAT - 1);

  lat_cls_t            cls;
  sb_entry_t           ent [NREG];
  logic                long_busy_q;
  logic                src1_pend, src2_pend;
  logic                rd1_ok, rd2_ok;
  logic                waw, structural, stall, record;
  logic [SB_LAT_W-1:0] alloc_cnt;
  logic                alloc_rdy;

  assign cls    = lat_cls_t'(id_cls);
  assign ent[0] = '0;

  // A same-cycle writeback reads through the write-first regfile.
  assign src1_pend = id_use1 && (id_ra1 != '0) && ent[id_ra1].pend && !(wb_valid && (wb_rd == id_ra1));
  assign src2_pend = id_use2 && (id_ra2 != '0) && ent[id_ra2].pend && !(wb_valid && (wb_rd == id_ra2));

`ifdef HAZARD_FORWARD_EN
  assign rd1_ok   = ent[id_ra1].rdy;
  assign rd2_ok   = ent[id_ra2].rdy;
  assign fwd_sel1 = (id_valid && src1_pend) ? age_to_fwd(ent[id_ra1].age) : FWD_RF;
  assign fwd_sel2 = (id_valid && src2_pend) ? age_to_fwd(ent[id_ra2].age) : FWD_RF;
`else
  assign rd1_ok   = 1'b0;
  assign rd2_ok   = 1'b0;
  assign fwd_sel1 = FWD_RF;
  assign fwd_sel2 = FWD_RF;
`endif

  assign waw        = id_wen && (id_rd != '0) && ent[id_rd].pend && !(wb_valid && (wb_rd == id_rd));
  assign structural = (cls == CLS_LONG) && long_busy_q && !long_done;

  assign stall = id_valid && !ex_redirect &&
                 ((src1_pend && !rd1_ok) || (src2_pend && !rd2_ok) || waw || structural);

  assign issue       = id_valid && !stall && !ex_redirect;
  assign stall_if    = stall;
  assign bubble_ex   = stall || ex_redirect;
  assign flush_if_id = ex_redirect;
  assign long_busy   = long_busy_q;

  assign record    = issue && id_wen && (id_rd != '0) && (cls != CLS_NONE);
  assign alloc_cnt = (cls == CLS_LOAD) ? SB_LAT_W'(LOAD_CNT) : '0;
  assign alloc_rdy = (cls != CLS_LONG) && (alloc_cnt == '0);

  // A new long op issued on the completion cycle keeps the unit busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          long_busy_q <= 1'b0;
    else if (issue && cls == CLS_LONG)  long_busy_q <= 1'b1;
    else if (long_done)                 long_busy_q <= 1'b0;
  end

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    hazard_sb_entry #(
      .NSTAGE (NSTAGE)
    ) u_ent (
      .clk       (clk),
      .reset     (reset),
      .alloc     (record && (id_rd == RW'(r))),
      .alloc_cnt (alloc_cnt),
      .alloc_rdy (alloc_rdy),
      .wb_clr    (wb_valid && (wb_rd == RW'(r))),
      .long_hit  (long_done && (long_rd == RW'(r))),
      .entry     (ent[r])
    );

    logic unused_fields;
    assign unused_fields = ^{ent[r].rdy, ent[r].cnt, ent[r].age};
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard; expectations follow HAZARD_FORWARD_EN when defined.
module tb_hazard_scoreboard;
  import pipes::*;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use1, id_use2, id_wen, long_done, wb_valid, ex_redirect;
  logic [4:0] id_ra1, id_ra2, id_rd, long_rd, wb_rd;
  logic [1:0] id_cls;
  logic       stall_if, bubble_ex, flush_if_id, issue, long_busy;
  logic [1:0] fwd_sel1, fwd_sel2;

  hazard_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_ra1      (id_ra1),
    .id_ra2      (id_ra2),
    .id_use1     (id_use1),
    .id_use2     (id_use2),
    .id_rd       (id_rd),
    .id_wen      (id_wen),
    .id_cls      (id_cls),
    .long_done   (long_done),
    .long_rd     (long_rd),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .ex_redirect (ex_redirect),
    .stall_if    (stall_if),
    .bubble_ex   (bubble_ex),
    .flush_if_id (flush_if_id),
    .issue       (issue),
    .fwd_sel1    (fwd_sel1),
    .fwd_sel2    (fwd_sel2),
    .long_busy   (long_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       valid, use1, use2, wen, wbv, ld, redir;
    logic [4:0] ra1, ra2, rd, wbrd, ldrd;
    logic [1:0] cls;
    logic       e_stall, e_issue, e_busy;
    logic [1:0] e_fwd1, e_fwd2;
  } vec_t;

  typedef struct {
    string      name;
    logic [9:0] w;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // wbrd < 0 means no writeback this cycle.
  function automatic vec_t mk(string n, int valid, int ra1, int u1, int ra2, int u2, int rd, int wen,
                              lat_cls_t cls, int wbrd, int redir, int st, int iss, int f1, int f2);
    vec_t v;
    v.name    = n;
    v.valid   = 1'(valid);
    v.ra1     = 5'(ra1);
    v.use1    = 1'(u1);
    v.ra2     = 5'(ra2);
    v.use2    = 1'(u2);
    v.rd      = 5'(rd);
    v.wen     = 1'(wen);
    v.cls     = 2'(cls);
    v.wbv     = (wbrd >= 0);
    v.wbrd    = (wbrd >= 0) ? 5'(wbrd) : 5'd0;
    v.redir   = 1'(redir);
    v.ld      = 1'b0;
    v.ldrd    = 5'd0;
    v.e_stall = 1'(st);
    v.e_issue = 1'(iss);
    v.e_fwd1  = 2'(f1);
    v.e_fwd2  = 2'(f2);
    v.e_busy  = 1'b0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_valid    = v.valid;
    id_ra1      = v.ra1;
    id_use1     = v.use1;
    id_ra2      = v.ra2;
    id_use2     = v.use2;
    id_rd       = v.rd;
    id_wen      = v.wen;
    id_cls      = v.cls;
    wb_valid    = v.wbv;
    wb_rd       = v.wbrd;
    long_done   = v.ld;
    long_rd     = v.ldrd;
    ex_redirect = v.redir;
  endtask

  // Expected word: stall_if, bubble_ex, flush_if_id, issue, fwd_sel1, fwd_sel2, long_busy.
  task automatic expect_push(input vec_t v);
    exp_t e;
    e.name = v.name;
    e.w    = {v.e_stall, v.e_stall | v.redir, v.redir, v.e_issue, v.e_fwd1, v.e_fwd2, v.e_busy};
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [9:0] act;
    act = {stall_if, bubble_ex, flush_if_id, issue, fwd_sel1, fwd_sel2, long_busy};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %b with no expected entry", act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e.w) begin
        n_fail++;
        $display("FAIL %s: got stall/bub/flush/iss/f1/f2/busy=%b required %b", e.name, act, e.w);
      end
    end
  endtask

  task automatic cyc(input vec_t v);
    @(negedge clk);
    drive(v);
    expect_push(v);
    #2 check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    reset = 1'b1;
    drive(mk("init", 0, 0, 0, 0, 0, 0, 0, CLS_NONE, -1, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

`ifdef HAZARD_FORWARD_EN
    tbl.push_back(mk("reset_idle",     0, 0, 0, 0, 0, 0, 0, CLS_NONE, -1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("addi_x5",        1, 0, 1, 0, 0, 5, 1, CLS_ALU,  -1, 0, 0, 1, 0, 0));
    tbl.push_back(mk("add_x6_x5x5",    1, 5, 1, 5, 1, 6, 1, CLS_ALU,  -1, 0, 0, 1, 1, 1));
    tbl.push_back(mk("use_x5_mem",     1, 5, 1, 0, 0, 0, 0, CLS_ALU,  -1, 0, 0, 1, 2, 0));
    tbl.push_back(mk("use_x5wb_x6mem", 1, 5, 1, 6, 1, 0, 0, CLS_ALU,  -1, 0, 0, 1, 3, 2));
    tbl.push_back(mk("x5_wb_same",     1, 5, 1, 0, 0, 0, 0, CLS_ALU,   5, 0, 0, 1, 0, 0));
    tbl.push_back(mk("ld_x7",          1, 0, 0, 0, 0, 7, 1, CLS_LOAD,  6, 0, 0, 1, 0, 0));
    tbl.push_back(mk("ldu_stall",      1, 7, 1, 0, 0, 8, 1, CLS_ALU,  -1, 0, 1, 0, 1, 0));
    tbl.push_back(mk("ldu_go",         1, 7, 1, 0, 0, 8, 1, CLS_ALU,  -1, 0, 0, 1, 1, 0));
    tbl.push_back(mk("waw_x8",         1, 0, 0, 0, 0, 8, 1, CLS_ALU,  -1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("waw_x8_wb",      1, 0, 0, 0, 0, 8, 1, CLS_ALU,   8, 0, 0, 1, 0, 0));
    tbl.push_back(mk("x8_new_entry",   1, 8, 1, 0, 0, 0, 0, CLS_ALU,  -1, 0, 0, 1, 1, 0));
`else
    tbl.push_back(mk("reset_idle",     0, 0, 0, 0, 0, 0, 0, CLS_NONE, -1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("addi_x5",        1, 0, 1, 0, 0, 5, 1, CLS_ALU,  -1, 0, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk("add_x6_stall", 1, 5, 1, 5, 1, 6, 1, CLS_ALU,  -1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("add_x6_wb5",     1, 5, 1, 5, 1, 6, 1, CLS_ALU,   5, 0, 0, 1, 0, 0));
    tbl.push_back(mk("ld_x7",          1, 0, 0, 0, 0, 7, 1, CLS_LOAD,  6, 0, 0, 1, 0, 0));
    tbl.push_back(mk("ldu_stall",      1, 7, 1, 0, 0, 8, 1, CLS_ALU,  -1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("ldu_wb7",        1, 7, 1, 0, 0, 8, 1, CLS_ALU,   7, 0, 0, 1, 0, 0));
    tbl.push_back(mk("waw_x8",         1, 0, 0, 0, 0, 8, 1, CLS_ALU,  -1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("waw_x8_wb",      1, 0, 0, 0, 0, 8, 1, CLS_ALU,   8, 0, 0, 1, 0, 0));
    tbl.push_back(mk("x8_still_pend",  1, 8, 1, 0, 0, 0, 0, CLS_ALU,  -1, 0, 1, 0, 0, 0));
`endif
    tbl.push_back(mk("ld_x12",         1, 0, 0, 0, 0, 12, 1, CLS_LOAD, -1, 0, 0, 1, 0, 0));
    tbl.push_back(mk("redirect",       1, 12, 1, 0, 0, 11, 1, CLS_ALU, -1, 1, 0, 0, FWD ? 1 : 0, 0));
    tbl.push_back(mk("no_x11_x0",      1, 11, 1, 0, 1, 0, 0, CLS_ALU,  -1, 0, 0, 1, 0, 0));
    tbl.push_back(mk("unused_src",     1, 12, 0, 12, 0, 0, 0, CLS_ALU, -1, 0, 0, 1, 0, 0));

    foreach (tbl[i]) cyc(tbl[i]);

    // Long op with a dependent consumer; completion arrives 10 cycles after issue.
    cyc(mk("mul_x9", 1, 0, 0, 0, 0, 9, 1, CLS_LONG, -1, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 10; k++) begin
      v = mk("long_dep_stall", 1, 9, 1, 0, 0, 0, 0, CLS_ALU, -1, 0, 1, 0, FWD ? 1 : 0, 0);
      v.e_busy = 1'b1;
      if (k == 10) begin
        v.ld   = 1'b1;
        v.ldrd = 5'd9;
      end
      cyc(v);
    end
    cyc(mk("long_dep_after", 1, 9, 1, 0, 0, 0, 0, CLS_ALU, -1, 0, FWD ? 0 : 1, FWD ? 1 : 0, FWD ? 1 : 0, 0));
    cyc(mk("long_dep_wb",    1, 9, 1, 0, 0, 0, 0, CLS_ALU,  9, 0, 0, 1, 0, 0));

    // Second long op while the unit is busy.
    cyc(mk("mul_x13", 1, 0, 0, 0, 0, 13, 1, CLS_LONG, -1, 0, 0, 1, 0, 0));
    for (int k = 0; k < 4; k++) begin
      v = mk("mul_x14_busy", 1, 0, 0, 0, 0, 14, 1, CLS_LONG, -1, 0, 1, 0, 0, 0);
      v.e_busy = 1'b1;
      cyc(v);
    end
    v = mk("mul_x14_on_done", 1, 0, 0, 0, 0, 14, 1, CLS_LONG, -1, 0, 0, 1, 0, 0);
    v.e_busy = 1'b1; v.ld = 1'b1; v.ldrd = 5'd13;
    cyc(v);
    v = mk("busy_after_reissue", 0, 0, 0, 0, 0, 0, 0, CLS_NONE, -1, 0, 0, 0, 0, 0);
    v.e_busy = 1'b1;
    cyc(v);
    v = mk("done_x14", 0, 0, 0, 0, 0, 0, 0, CLS_NONE, -1, 0, 0, 0, 0, 0);
    v.e_busy = 1'b1; v.ld = 1'b1; v.ldrd = 5'd14;
    cyc(v);
    cyc(mk("busy_dropped", 0, 0, 0, 0, 0, 0, 0, CLS_NONE, -1, 0, 0, 0, 0, 0));

    // Asynchronous reset in the middle of a long op.
    cyc(mk("mul_x15", 1, 0, 0, 0, 0, 15, 1, CLS_LONG, -1, 0, 0, 1, 0, 0));
    @(negedge clk);
    v = mk("x15_pre_reset", 1, 15, 1, 0, 0, 0, 0, CLS_ALU, -1, 0, 1, 0, FWD ? 1 : 0, 0);
    v.e_busy = 1'b1;
    drive(v);
    expect_push(v);
    #1 check_out();
    #1 reset = 1'b1;
    v = mk("x15_in_reset", 1, 15, 1, 0, 0, 0, 0, CLS_ALU, -1, 0, 0, 1, 0, 0);
    expect_push(v);
    #1 check_out();
    #1 reset = 1'b0;
    cyc(mk("x15_after_reset", 1, 15, 1, 0, 0, 15, 1, CLS_ALU, -1, 0, 0, 1, 0, 0));

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
